apb4_mem_slave: RTL
===================

Name: apb4_mem_slave

Overview:
Parametrised APB4 memory slave, successor to the single-width APB memory slave. It generalises data width, depth and address width. It adds:
- byte-lane write strobes (PSTRB),
- programmable wait states,
- alignment checking,
- a write-protected region.

It sits on the peripheral bus as a memory-mapped scratch RAM and is the error-response target for protocol benches.

Parameters:
ADDR_WIDTH, 32, PADDR width in bits (byte address)
DATA_WIDTH, 32, PWDATA/PRDATA width; one of 8, 16, 32, 64
MEM_DEPTH, 1024, number of DATA_WIDTH words
WAIT_STATES, 0, extra PREADY-low cycles inserted per transfer (0..15)
WP_BASE, 0, first word index of the write-protected region
WP_SIZE, 0, word count of the write-protected region; 0 disables protection

Ports:
PCLK  input  1  bus clock; all state updates on rising edge
PRESET  input  1  asynchronous, active-high reset
PSEL  input  1  slave select
PENABLE  input  1  access-phase indicator
PWRITE  input  1  1 = write, 0 = read
PADDR  input  ADDR_WIDTH  byte address
PWDATA  input  DATA_WIDTH  write data
PSTRB  input  DATA_WIDTH/8  write byte-lane enables
PRDATA  output  DATA_WIDTH  read data, valid in the completion cycle
PREADY  output  1  transfer completion
PSLVERR  output  1  error response, valid in the completion cycle

Behaviour:
- Reset (PRESET high, asynchronous): state=IDLE, PREADY=0, PSLVERR=0, PRDATA=0, wait counter=0. Memory contents are not cleared.
- Memory is initialised at time zero to MEM[i]=i, truncated to DATA_WIDTH.
- Word index = PADDR >> log2(DATA_WIDTH/8). Low PADDR bits below that shift are the alignment bits.
- All outputs are registered. PREADY is high only in the completion cycle and low at all other times.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - PSEL=1 and PENABLE=0 (setup phase): capture PADDR, PWRITE, PWDATA, PSTRB; load counter=WAIT_STATES; go to WAIT.
  - Otherwise remain in IDLE.
- WAIT:
  - PSEL=0: abort; go to IDLE; no memory update, no response.
  - PSEL=1, PENABLE=1, counter>0: decrement counter; remain in WAIT.
  - PSEL=1, PENABLE=1, counter=0: execute the captured transfer; PREADY<=1; go to DONE.
  - PSEL=1, PENABLE=0: remain in WAIT; counter holds.
- Timing: if the setup phase is cycle 0, PREADY is high in cycle WAIT_STATES+2. The transfer therefore has WAIT_STATES+1 low-PREADY access cycles.
- DONE (one cycle, PREADY=1) drives the response. At the next edge:
  - PREADY<=0 and PSLVERR<=0.
  - PSEL=1 and PENABLE=0: back-to-back setup; capture and go to WAIT.
  - Otherwise go to IDLE.
- PRDATA holds its last value until the next completing read or error.
- Error conditions, checked on the captured values (any one sets PSLVERR=1 in DONE):
  - word index >= MEM_DEPTH;
  - alignment bits nonzero;
  - read with PSTRB != 0;
  - write with word index in [WP_BASE, WP_BASE+WP_SIZE) and WP_SIZE != 0.
- On error: no memory update, PRDATA<=0.
- Good write: for each lane b with PSTRB[b]=1, MEM[idx][8b+7:8b] <= PWDATA byte b; other lanes unchanged. PSTRB=0 completes OKAY with no change. PRDATA is unchanged.
- Good read: PRDATA <= MEM[idx].
- Read and write never complete in the same cycle; at most one transfer is outstanding.
- Address comparison uses the full ADDR_WIDTH. Out-of-range addresses never wrap into the array.
- Reset asserted mid-transfer: the transfer is dropped, memory is not written, outputs go to reset values immediately.
- Illegal state encoding: recover to IDLE.

Test Plan:
1. DATA_WIDTH=32, WAIT_STATES=0: read PADDR=0x10 with no prior writes -> PREADY high in cycle 2, PRDATA=0x00000004, PSLVERR=0.
2. Write PADDR=0x20, PWDATA=0xAABBCCDD, PSTRB=4'b0101, then read 0x20 -> PRDATA=0x00BB00DD (initial value 8 overwritten in lanes 0 and 2, so final value 0x00BB00DD), PSLVERR=0 on both transfers.
3. WAIT_STATES=3: single read -> PREADY low for 4 access cycles and high in cycle 5. Back-to-back setup in DONE -> second PREADY in cycle 10.
4. Error responses -> PSLVERR=1, PRDATA=0 for each of:
   - PADDR=0x1000 (index 1024);
   - PADDR=0x22 (misaligned);
   - read with PSTRB=4'b0001;
   - WP_BASE=8, WP_SIZE=4, write 0x24.
   A follow-up read of 0x24 returns 9, confirming no update.
5. PSEL dropped in WAIT during a write to 0x30 -> no PREADY pulse, FSM in IDLE, read of 0x30 returns 12.
6. PRESET pulsed for 1 cycle during WAIT of a write to 0x40 -> PREADY=0, PSLVERR=0, PRDATA=0 immediately; read of 0x40 returns 16.

Source files
------------

// File: rtl/apb4_mem_slave.sv
// APB4 scratch-RAM slave with byte-lane strobes, programmable wait states,
// alignment/range checking and an optional write-protected word range.
module apb4_mem_slave #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_STATES = 0,
    parameter int WP_BASE     = 0,
    parameter int WP_SIZE     = 0
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR
);
    localparam int NUM_LANES = DATA_WIDTH / 8;
    localparam int SHIFT     = $clog2(NUM_LANES);
    localparam int IDX_WIDTH = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [3:0]             r_cnt, w_cnt_nxt;
    logic [ADDR_WIDTH-1:0]  r_addr, w_addr_nxt;
    logic                   r_write, w_write_nxt;
    logic [DATA_WIDTH-1:0]  r_wdata, w_wdata_nxt;
    logic [NUM_LANES-1:0]   r_strb, w_strb_nxt;
    logic [DATA_WIDTH-1:0]  r_prdata, w_prdata_nxt;
    logic                   r_pready, w_pready_nxt;
    logic                   r_pslverr, w_pslverr_nxt;

    logic                   w_setup;
    logic                   w_capture;
    logic                   w_mem_we;
    logic [ADDR_WIDTH-1:0]  w_idx_full;
    logic [IDX_WIDTH-1:0]   w_idx;
    logic                   w_err_range;
    logic                   w_err_align;
    logic                   w_err_strb;
    logic                   w_err_wp;
    logic                   w_error;
    logic [DATA_WIDTH-1:0]  w_mem [MEM_DEPTH];

    assign w_setup    = PSEL && !PENABLE;
    assign w_idx_full = r_addr >> SHIFT;
    assign w_idx      = w_idx_full[IDX_WIDTH-1:0];

    // Range checks use the full captured index so large addresses never alias into the array.
    assign w_err_range = 64'(w_idx_full) >= 64'(MEM_DEPTH);
    assign w_err_align = (r_addr & ADDR_WIDTH'((1 << SHIFT) - 1)) != '0;
    assign w_err_strb  = !r_write && (r_strb != '0);
    assign w_err_wp    = r_write && (WP_SIZE != 0)
                         && (64'(w_idx_full) >= 64'(WP_BASE))
                         && (64'(w_idx_full) <  64'(WP_BASE) + 64'(WP_SIZE));
    assign w_error     = w_err_range || w_err_align || w_err_strb || w_err_wp;

    for (genvar gi = 0; gi < MEM_DEPTH; gi++) begin : g_word
        // NOTE: storage has no reset; contents survive PRESET and start from the power-up image word i = i.
        logic [DATA_WIDTH-1:0] r_word = DATA_WIDTH'(gi);

        always_ff @(posedge PCLK) begin
            if (w_mem_we && (w_idx == IDX_WIDTH'(gi))) begin
                for (int b = 0; b < NUM_LANES; b++) begin
                    if (r_strb[b]) begin
                        r_word[8*b +: 8] <= r_wdata[8*b +: 8];
                    end
                end
            end
        end

        assign w_mem[gi] = r_word;
    end

    always_comb begin
        // NOTE: every next-value signal is defaulted first so no branch can infer a latch.
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_addr_nxt    = r_addr;
        w_write_nxt   = r_write;
        w_wdata_nxt   = r_wdata;
        w_strb_nxt    = r_strb;
        w_prdata_nxt  = r_prdata;
        w_pready_nxt  = 1'b0;
        w_pslverr_nxt = 1'b0;
        w_mem_we      = 1'b0;
        w_capture     = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_capture = w_setup;
            end
            S_WAIT: begin
                if (!PSEL) begin
                    w_state_nxt = S_IDLE;
                end else if (PENABLE) begin
                    if (r_cnt != 4'd0) begin
                        w_cnt_nxt = r_cnt - 4'd1;
                    end else begin
                        w_pready_nxt = 1'b1;
                        w_state_nxt  = S_DONE;
                        if (w_error) begin
                            w_pslverr_nxt = 1'b1;
                            w_prdata_nxt  = '0;
                        end else if (r_write) begin
                            w_mem_we = 1'b1;
                        end else begin
                            w_prdata_nxt = w_mem[w_idx];
                        end
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_capture   = w_setup;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // A setup phase seen in IDLE or DONE starts a new transfer.
        if (w_capture) begin
            w_addr_nxt  = PADDR;
            w_write_nxt = PWRITE;
            w_wdata_nxt = PWDATA;
            w_strb_nxt  = PSTRB;
            w_cnt_nxt   = 4'(WAIT_STATES);
            w_state_nxt = S_WAIT;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_addr    <= '0;
            r_write   <= 1'b0;
            r_wdata   <= '0;
            r_strb    <= '0;
            r_prdata  <= '0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_addr    <= w_addr_nxt;
            r_write   <= w_write_nxt;
            r_wdata   <= w_wdata_nxt;
            r_strb    <= w_strb_nxt;
            r_prdata  <= w_prdata_nxt;
            r_pready  <= w_pready_nxt;
            r_pslverr <= w_pslverr_nxt;
        end
    end

    assign PRDATA  = r_prdata;
    assign PREADY  = r_pready;
    assign PSLVERR = r_pslverr;

endmodule
